// File: rtl/ls161_pkg.sv
// rtl/ls161_pkg.sv - shared constants and types for the ls161 down-counter family.
package ls161_pkg;

  localparam int SLICE_W = 4;

  typedef logic [3:0] nibble_t;

  // A chain is only well formed when it splits into whole 4-bit slices.
  function automatic bit width_ok(input int w);
    return (w > 0) && ((w % SLICE_W) == 0);
  endfunction

endpackage

// File: rtl/ls161_down_slice.sv
// rtl/ls161_down_slice.sv - one 4-bit presettable down-count stage with borrow out.
// Macro LS161_DOWN_AUTORELOAD_EN: an enabled decrement from 0 takes reload_val.
module ls161_down_slice
  import ls161_pkg::*;
(
  input  logic    CLK,
  input  logic    CLR_n,
  input  nibble_t D,
  input  logic    LOAD_n,
  input  logic    ENP,
  input  logic    ENT,
  input  nibble_t reload_val,
  output nibble_t Q,
  output logic    BO
);

  nibble_t next_q;

`ifdef LS161_DOWN_AUTORELOAD_EN
  // The top drives all-ones here unless the whole chain is at zero, so a
  // lower slice still wraps normally while an upper slice borrows from it.
  always_comb begin
    next_q = Q - 4'd1;
    if (Q == 4'd0) next_q = reload_val;
  end
`else
  logic unused_reload;
  assign unused_reload = ^reload_val;

  always_comb begin
    next_q = Q - 4'd1;
  end
`endif

  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n)          Q <= '0;
    else if (!LOAD_n)    Q <= D;
    else if (ENP && ENT) Q <= next_q;
  end

  assign BO = ENT & (Q == 4'd0);

endmodule

// File: rtl/ls161_down.sv
// rtl/ls161_down.sv - WIDTH-bit synchronous presettable down counter built from 4-bit slices.
// Macro LS161_DOWN_AUTORELOAD_EN: reload register R replaces the wrap from zero.
module ls161_down
  import ls161_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             CLR_n,
  input  logic [WIDTH-1:0] D,
  input  logic             LOAD_n,
  input  logic             ENP,
  input  logic             ENT,
  output logic [WIDTH-1:0] Q,
  output logic             BO
);

  localparam bit WIDTH_OK = width_ok(WIDTH);
  localparam int NSLICE   = WIDTH / SLICE_W;

  if (!WIDTH_OK) begin : g_bad_width
    $error("ls161_down: WIDTH must be a positive multiple of 4");
  end

  logic [NSLICE:0]   ent_chain;
  logic [WIDTH-1:0]  reload_bus;

  assign ent_chain[0] = ENT;
  assign BO           = ent_chain[NSLICE];

`ifdef LS161_DOWN_AUTORELOAD_EN
  logic [WIDTH-1:0] r;

  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n)       r <= '0;
    else if (!LOAD_n) r <= D;
  end

  // Only a full-chain zero reloads; otherwise each slice wraps to F.
  assign reload_bus = (Q == '0) ? r : '1;
`else
  assign reload_bus = '1;
`endif

  for (genvar k = 0; k < NSLICE; k++) begin : g_slice
    ls161_down_slice u_slice (
      .CLK        (CLK),
      .CLR_n      (CLR_n),
      .D          (D[k*SLICE_W +: SLICE_W]),
      .LOAD_n     (LOAD_n),
      .ENP        (ENP),
      .ENT        (ent_chain[k]),
      .reload_val (reload_bus[k*SLICE_W +: SLICE_W]),
      .Q          (Q[k*SLICE_W +: SLICE_W]),
      .BO         (ent_chain[k+1])
    );
  end

endmodule

// File: tb/tb_ls161_down.sv
// tb/tb_ls161_down.sv - directed scoreboard bench for 4-bit and 8-bit ls161_down.
// Expectations follow LS161_DOWN_AUTORELOAD_EN when it is defined.
module tb_ls161_down;

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;

  logic [3:0] a_d = '0;
  logic       a_load_n = 1'b1, a_enp = 1'b0, a_ent = 1'b1;
  logic [3:0] a_q;
  logic       a_bo;

  logic [7:0] b_d = '0;
  logic       b_load_n = 1'b1, b_enp = 1'b0, b_ent = 1'b1;
  logic [7:0] b_q;
  logic       b_bo;

  int passed = 0;
  int total  = 0;

  logic [7:0] sb_q[$];
  logic       sb_bo[$];

  ls161_down #(.WIDTH(4)) u_a (
    .CLK(clk), .CLR_n(clr_n), .D(a_d), .LOAD_n(a_load_n),
    .ENP(a_enp), .ENT(a_ent), .Q(a_q), .BO(a_bo)
  );

  ls161_down #(.WIDTH(8)) u_b (
    .CLK(clk), .CLR_n(clr_n), .D(b_d), .LOAD_n(b_load_n),
    .ENP(b_enp), .ENT(b_ent), .Q(b_q), .BO(b_bo)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [7:0] q, input logic bo);
    sb_q.push_back(q);
    sb_bo.push_back(bo);
  endtask

  task automatic compare(input string tag, input logic [7:0] q_obs, input logic bo_obs);
    logic [7:0] q_exp;
    logic       bo_exp;
    total++;
    assert (sb_q.size() > 0) passed++;
    else $error("FAIL %s scoreboard empty: observed q=%h bo=%b required an entry", tag, q_obs, bo_obs);
    if (sb_q.size() > 0) begin
      q_exp  = sb_q.pop_front();
      bo_exp = sb_bo.pop_front();
      total++;
      assert (q_obs === q_exp) passed++;
      else $error("FAIL %s q: observed %h required %h", tag, q_obs, q_exp);
      total++;
      assert (bo_obs === bo_exp) passed++;
      else $error("FAIL %s bo: observed %b required %b", tag, bo_obs, bo_exp);
    end
  endtask

  // Drive the 4-bit counter at the falling edge, check #1 after the rising edge.
  task automatic a_step(input string tag, input logic load_n, input logic [3:0] d,
                        input logic enp, input logic ent,
                        input logic [3:0] q_exp, input logic bo_exp);
    a_load_n = load_n; a_d = d; a_enp = enp; a_ent = ent;
    push({4'h0, q_exp}, bo_exp);
    @(posedge clk); #1;
    compare(tag, {4'h0, a_q}, a_bo);
    @(negedge clk);
  endtask

  task automatic b_step(input string tag, input logic load_n, input logic [7:0] d,
                        input logic enp, input logic ent,
                        input logic [7:0] q_exp, input logic bo_exp);
    b_load_n = load_n; b_d = d; b_enp = enp; b_ent = ent;
    push(q_exp, bo_exp);
    @(posedge clk); #1;
    compare(tag, b_q, b_bo);
    @(negedge clk);
  endtask

  logic [3:0] model_q;
  logic [3:0] a_reload;

  initial begin
    // Reset state with no clock edge required
    #2;
    push(8'h00, 1'b1); compare("reset_a", {4'h0, a_q}, a_bo);
    push(8'h00, 1'b1); compare("reset_b", b_q, b_bo);
    @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);

    // Asynchronous clear mid-count
    a_step("load9", 1'b0, 4'h9, 1'b0, 1'b1, 4'h9, 1'b0);
    #2 clr_n = 1'b0; #1;
    push(8'h00, 1'b1); compare("async_clr", {4'h0, a_q}, a_bo);
    a_ent = 1'b0; #1;
    push(8'h00, 1'b0); compare("clr_bo_ent0", {4'h0, a_q}, a_bo);
    clr_n = 1'b1; a_ent = 1'b1; #1;
    push(8'h00, 1'b1); compare("clr_release", {4'h0, a_q}, a_bo);
    @(negedge clk);

    // Load beats count
    a_step("load_prio", 1'b0, 4'h5, 1'b1, 1'b1, 4'h5, 1'b0);
    a_step("count_after_load", 1'b1, 4'h0, 1'b1, 1'b1, 4'h4, 1'b0);

    // Enable gating
    a_step("load3", 1'b0, 4'h3, 1'b0, 1'b0, 4'h3, 1'b0);
    for (int i = 0; i < 3; i++) a_step("enp0_hold", 1'b1, 4'h0, 1'b0, 1'b1, 4'h3, 1'b0);
    for (int i = 0; i < 3; i++) a_step("ent0_hold", 1'b1, 4'h0, 1'b1, 1'b0, 4'h3, 1'b0);
    a_step("dec_2", 1'b1, 4'h0, 1'b1, 1'b1, 4'h2, 1'b0);
    a_step("dec_1", 1'b1, 4'h0, 1'b1, 1'b1, 4'h1, 1'b0);
    a_step("dec_0", 1'b1, 4'h0, 1'b1, 1'b1, 4'h0, 1'b1);
    #2 a_ent = 1'b0; #1;
    push(8'h00, 1'b0); compare("drop_ent_bo", {4'h0, a_q}, a_bo);
    @(negedge clk);

    // Decrement from zero: wrap, or reload from the last loaded value (3)
`ifdef LS161_DOWN_AUTORELOAD_EN
    a_step("zero_next", 1'b1, 4'h0, 1'b1, 1'b1, 4'h3, 1'b0);
`else
    a_step("zero_next", 1'b1, 4'h0, 1'b1, 1'b1, 4'hF, 1'b0);
`endif

    // Continuous count after loading 2
`ifdef LS161_DOWN_AUTORELOAD_EN
    a_reload = 4'h2;
`else
    a_reload = 4'hF;
`endif
    model_q = 4'h2;
    a_step("load2", 1'b0, 4'h2, 1'b0, 1'b1, model_q, 1'b0);
    for (int i = 0; i < 6; i++) begin
      model_q = (model_q == 4'h0) ? a_reload : model_q - 4'h1;
      a_step("run", 1'b1, 4'h0, 1'b1, 1'b1, model_q, model_q == 4'h0);
    end

    // Cascade across the nibble boundary
    b_step("b_load10", 1'b0, 8'h10, 1'b1, 1'b1, 8'h10, 1'b0);
    b_step("b_borrow", 1'b1, 8'h00, 1'b1, 1'b1, 8'h0F, 1'b0);
    b_step("b_hold", 1'b1, 8'h00, 1'b1, 1'b0, 8'h0F, 1'b0);
    b_step("b_load00", 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1);
    b_ent = 1'b0; #1;
    push(8'h00, 1'b0); compare("b_bo_ent0", b_q, b_bo);
    @(negedge clk);
`ifdef LS161_DOWN_AUTORELOAD_EN
    b_step("b_zero_next", 1'b1, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1);
`else
    b_step("b_zero_next", 1'b1, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0);
`endif
    b_step("b_load01", 1'b0, 8'h01, 1'b0, 1'b1, 8'h01, 1'b0);
    b_step("b_dec_0", 1'b1, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed no finish, required finish before 50000");
    $fatal(1, "timeout");
  end

endmodule
